// File: rtl/mdu_pkg.sv
// Shared constants and types for the HI/LO multiply/divide unit.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2
  } state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the decode/register-file side and the HI/LO unit.
// Handshake: start is accepted only on a clock edge where busy=0 and no MTHI/MTLO
// write is present; busy stays high until the op retires, and done pulses one cycle.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             hi_write_enable;
  logic             lo_write_enable;
  logic [WIDTH-1:0] write_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b, hi_write_enable, lo_write_enable, write_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, hi_write_enable, lo_write_enable, write_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_divider.sv
// Restoring unsigned divider: one quotient bit per enabled cycle, MSB first.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] diff;

  // Extra top bit of diff is the borrow: set means the trial subtract failed.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign diff      = {1'b0, rem_shift} - {2'b00, dvs_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (enable) begin
      if (!diff[WIDTH+1]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= rem_shift[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// MIPS HI/LO unit: iterative MULT/MULTU/DIV/DIVU over WIDTH steps, plus MTHI/MTLO.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic    clk,
  input  logic    reset,
  mult_div_unit_if.slave bus,
  output state_t  dbg_state
);

  localparam int CW = $clog2(WIDTH);

  state_t             state, next_state;
  logic [CW-1:0]      count;
  logic [1:0]         op_q;
  logic               sign_a, sign_b, div_zero;
  logic [WIDTH-1:0]   mag_a;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic               launch, step, commit, wr;
  logic               start_signed;
  logic [WIDTH-1:0]   abs_a, abs_b, quo, rem;
  logic [WIDTH:0]     sum;
  logic               neg_prod, neg_quo, neg_rem;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   div_hi, div_lo;

  assign wr           = bus.hi_write_enable | bus.lo_write_enable;
  assign start_signed = ~bus.op[0];
  assign abs_a = (start_signed && bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
  assign abs_b = (start_signed && bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;

  // An MTHI/MTLO write always wins: it cancels any op and suppresses a new start.
  always_comb begin
    next_state = state;
    launch     = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          next_state = ITER;
          launch     = 1'b1;
        end
      end
      ITER: begin
        step = 1'b1;
        if (count == CW'(WIDTH - 1)) next_state = FIXUP;
      end
      FIXUP: begin
        commit     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (wr) begin
      next_state = IDLE;
      launch     = 1'b0;
      step       = 1'b0;
      commit     = 1'b0;
    end
  end

  // Shift-add multiply: low half starts as the multiplier and drains out as product bits enter.
  assign sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_a} : '0);

  assign neg_prod = ~op_q[0] & (sign_a ^ sign_b);
  assign neg_quo  = ~op_q[0] & (sign_a ^ sign_b);
  assign neg_rem  = ~op_q[0] & sign_a;
  assign mul_res  = neg_prod ? -prod : prod;
  // With a zero divisor the remainder ends as |operand_a|, so re-signing it restores operand_a.
  assign div_hi   = neg_rem ? -rem : rem;
  assign div_lo   = div_zero ? '1 : (neg_quo ? -quo : quo);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      op_q     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      mag_a    <= '0;
      prod     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= commit;
      if (wr) begin
        if (bus.hi_write_enable) hi_q <= bus.write_data;
        if (bus.lo_write_enable) lo_q <= bus.write_data;
      end else if (commit) begin
        if (op_q[1]) begin
          hi_q <= div_hi;
          lo_q <= div_lo;
        end else begin
          hi_q <= mul_res[2*WIDTH-1:WIDTH];
          lo_q <= mul_res[WIDTH-1:0];
        end
      end
      if (launch) begin
        op_q     <= bus.op;
        sign_a   <= bus.operand_a[WIDTH-1];
        sign_b   <= bus.operand_b[WIDTH-1];
        div_zero <= (bus.operand_b == '0);
        mag_a    <= abs_a;
        prod     <= {{WIDTH{1'b0}}, abs_b};
        count    <= '0;
      end else if (step) begin
        count <= count + 1'b1;
        prod  <= {sum, prod[WIDTH-1:1]};
      end
    end
  end

  mdu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .reset     (reset),
    .load      (launch),
    .enable    (step),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quo),
    .remainder (rem)
  );

  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign dbg_state = state;

endmodule
